// File: rtl/bus_word_packer_if.sv
// Handshake bundle for bus_word_packer: the bus-side load port plus the
// valid/ready operand port. The slave modport is the packer's view.
interface bus_word_packer_if #(
  parameter int BUS_W = 8,
  parameter int WORDS = 2,
  parameter int CNT_W = $clog2(WORDS)
) ();

  logic [BUS_W-1:0]       bus;
  logic                   ld;
  logic                   ld_ready;
  logic                   clr;
  logic [CNT_W-1:0]       cnt;
  logic [BUS_W*WORDS-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   cntco;

  modport slave (
    input  bus,
    input  ld,
    input  clr,
    input  out_ready,
    output ld_ready,
    output cnt,
    output out_data,
    output out_valid,
    output cntco
  );

  modport master (
    output bus,
    output ld,
    output clr,
    output out_ready,
    input  ld_ready,
    input  cnt,
    input  out_data,
    input  out_valid,
    input  cntco
  );

endinterface

// File: rtl/bus_word_packer.sv
// Collects WORDS bus words into one wide operand behind a registered valid/ready stage.
// Build option PACKER_MSB_FIRST_EN: first-accepted word lands in the most-significant slot.
module bus_word_packer #(
  parameter int BUS_W = 8,
  parameter int WORDS = 2,
  parameter int CNT_W = $clog2(WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  bus_word_packer_if.slave bif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  logic [WORDS-2:0][BUS_W-1:0] slot_q;
  logic [WORDS-2:0][BUS_W-1:0] slot_d;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;
  logic [BUS_W*WORDS-1:0]      out_data_q;
  logic [BUS_W*WORDS-1:0]      out_data_d;
  logic                        out_valid_q;
  logic                        out_valid_d;
  logic                        cntco_q;
  logic                        cntco_d;

  logic [WORDS-1:0][BUS_W-1:0] assembled;
  logic                        ld_ready;
  logic                        accept;
  logic                        complete;
  logic                        consume;

  // Only the completing word can stall; partial words always find a free slot.
  always_comb begin
    ld_ready = (cnt_q != LAST) || !out_valid_q || bif.out_ready;
    accept   = bif.ld && ld_ready && !bif.clr;
    complete = accept && (cnt_q == LAST);
    consume  = out_valid_q && bif.out_ready;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WORDS - 1; gi++) begin : g_slot
`ifdef PACKER_MSB_FIRST_EN
      localparam int POS = WORDS - 1 - gi;
`else
      localparam int POS = gi;
`endif
      assign slot_d[gi]     = bif.clr ? '0
                            : (accept && (cnt_q == CNT_W'(gi))) ? bif.bus
                            : slot_q[gi];
      assign assembled[POS] = slot_q[gi];
    end
  endgenerate

  // The completing word bypasses the slots and goes straight into the operand.
`ifdef PACKER_MSB_FIRST_EN
  assign assembled[0] = bif.bus;
`else
  assign assembled[WORDS-1] = bif.bus;
`endif

  always_comb begin
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cntco_d     = 1'b0;

    if (bif.clr) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = complete ? '0 : cnt_q + CNT_W'(1);
    end

    if (complete) begin
      out_data_d  = assembled;
      out_valid_d = 1'b1;
      cntco_d     = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cntco_q     <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cntco_q     <= cntco_d;
    end
  end

  assign bif.ld_ready  = ld_ready;
  assign bif.cnt       = cnt_q;
  assign bif.out_data  = out_data_q;
  assign bif.out_valid = out_valid_q;
  assign bif.cntco     = cntco_q;

endmodule

// File: tb/tb_bus_word_packer.sv
// Self-checking bench for bus_word_packer: vector table on a 2-word instance,
// directed corner sequences, and a randomized run of a 4-word instance against a queue model.
module tb_bus_word_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_word_packer_if #(.BUS_W(8), .WORDS(2)) if2 ();
  bus_word_packer_if #(.BUS_W(8), .WORDS(4)) if4 ();

  bus_word_packer #(.BUS_W(8), .WORDS(2)) dut2 (.clk(clk), .rst(rst), .bif(if2.slave));
  bus_word_packer #(.BUS_W(8), .WORDS(4)) dut4 (.clk(clk), .rst(rst), .bif(if4.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Operand from words in arrival order, following the packing rule of the build.
  function automatic logic [31:0] pack(input logic [7:0] w[$]);
    logic [31:0] r;
    int n;
    int p;
    r = '0;
    n = w.size();
    for (int k = 0; k < n; k++) begin
`ifdef PACKER_MSB_FIRST_EN
      p = n - 1 - k;
`else
      p = k;
`endif
      r[p*8 +: 8] = w[k];
    end
    return r;
  endfunction

  function automatic logic [15:0] p2(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] q[$];
    logic [31:0] r;
    q.push_back(a);
    q.push_back(b);
    r = pack(q);
    return r[15:0];
  endfunction

  typedef struct {
    logic        ld;
    logic        clr;
    logic        ordy;
    logic [7:0]  bus;
    logic        rdy;
    logic        cnt;
    logic        v;
    logic [15:0] data;
    logic        co;
  } vec_t;

  function automatic vec_t mk(input logic ld, input logic clr, input logic ordy, input logic [7:0] bus,
                              input logic rdy, input logic cnt, input logic v, input logic [15:0] data,
                              input logic co);
    vec_t t;
    t.ld = ld; t.clr = clr; t.ordy = ordy; t.bus = bus;
    t.rdy = rdy; t.cnt = cnt; t.v = v; t.data = data; t.co = co;
    return t;
  endfunction

  task automatic cyc2(input logic ld, input logic [7:0] bus, input logic clr, input logic ordy);
    if2.ld = ld; if2.bus = bus; if2.clr = clr; if2.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  vec_t tv[17];

  initial begin
    logic [15:0] d1, da, db, d01, d78;
    logic [7:0] wq[$];
    logic [7:0] part[$];
    logic [31:0] sb[$];
    logic [31:0] md;
    logic [31:0] nd;
    logic mv, done, e_rdy, r_ld, r_clr, r_ordy;
    logic [7:0] r_bus;
    int n_done, n_co;

    if2.ld = 0; if2.bus = '0; if2.clr = 0; if2.out_ready = 0;
    if4.ld = 0; if4.bus = '0; if4.clr = 0; if4.out_ready = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset cnt",       64'(if2.cnt),       64'd0);
    chk("reset out_valid", 64'(if2.out_valid), 64'd0);
    chk("reset out_data",  64'(if2.out_data),  64'd0);
    chk("reset cntco",     64'(if2.cntco),     64'd0);
    chk("reset ld_ready",  64'(if2.ld_ready),  64'd1);
    chk("reset w4 data",   64'(if4.out_data),  64'd0);
    $display("reset: cnt=%0d valid=%0b data=0x%0h ld_ready=%0b", if2.cnt, if2.out_valid, if2.out_data, if2.ld_ready);

    d1 = p2(8'h34, 8'h12); da = p2(8'hA1, 8'hA2); db = p2(8'hB1, 8'hB2);
    d01 = p2(8'h01, 8'h02); d78 = p2(8'h07, 8'h08);
    tv[0]  = mk(1, 0, 1, 8'h34, 1, 1, 0, 16'h0, 0);
    tv[1]  = mk(1, 0, 1, 8'h12, 1, 0, 1, d1,    1);
    tv[2]  = mk(0, 0, 1, 8'h00, 1, 0, 0, d1,    0);
    tv[3]  = mk(1, 0, 0, 8'hA1, 1, 1, 0, d1,    0);
    tv[4]  = mk(1, 0, 0, 8'hA2, 1, 0, 1, da,    1);
    tv[5]  = mk(1, 0, 0, 8'hB1, 1, 1, 1, da,    0);
    tv[6]  = mk(1, 0, 0, 8'hB2, 0, 1, 1, da,    0);
    tv[7]  = mk(1, 0, 1, 8'hB2, 1, 0, 1, db,    1);
    tv[8]  = mk(0, 0, 1, 8'h00, 1, 0, 0, db,    0);
    tv[9]  = mk(1, 0, 1, 8'h55, 1, 1, 0, db,    0);
    tv[10] = mk(1, 1, 1, 8'h66, 1, 0, 0, db,    0);
    tv[11] = mk(1, 0, 1, 8'h01, 1, 1, 0, db,    0);
    tv[12] = mk(1, 0, 1, 8'h02, 1, 0, 1, d01,   1);
    tv[13] = mk(1, 0, 0, 8'h07, 1, 1, 1, d01,   0);
    tv[14] = mk(1, 0, 1, 8'h08, 1, 0, 1, d78,   1);
    tv[15] = mk(1, 1, 0, 8'h09, 1, 0, 1, d78,   0);
    tv[16] = mk(0, 0, 1, 8'h00, 1, 0, 0, d78,   0);

    for (int i = 0; i < 17; i++) begin
      if2.ld = tv[i].ld; if2.clr = tv[i].clr; if2.out_ready = tv[i].ordy; if2.bus = tv[i].bus;
      #1;
      chk($sformatf("vec%0d ld_ready", i), 64'(if2.ld_ready), 64'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d cnt", i),       64'(if2.cnt),       64'(tv[i].cnt));
      chk($sformatf("vec%0d out_valid", i), 64'(if2.out_valid), 64'(tv[i].v));
      chk($sformatf("vec%0d out_data", i),  64'(if2.out_data),  64'(tv[i].data));
      chk($sformatf("vec%0d cntco", i),     64'(if2.cntco),     64'(tv[i].co));
      $display("vec%0d: ld=%0b clr=%0b ordy=%0b bus=0x%0h -> cnt=%0d valid=%0b data=0x%0h cntco=%0b",
               i, tv[i].ld, tv[i].clr, tv[i].ordy, tv[i].bus, if2.cnt, if2.out_valid, if2.out_data, if2.cntco);
    end

    // Asynchronous reset mid-assembly, then while an operand is pending.
    cyc2(1, 8'h77, 0, 0);
    if2.ld = 0;
    chk("pre-rst cnt", 64'(if2.cnt), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst cnt",      64'(if2.cnt),      64'd0);
    chk("async rst ld_ready", 64'(if2.ld_ready), 64'd1);
    rst = 1'b0;
    $display("async reset mid-assembly: cnt=%0d", if2.cnt);
    cyc2(1, 8'h10, 0, 0);
    cyc2(1, 8'h20, 0, 0);
    if2.ld = 0;
    chk("pre-rst valid", 64'(if2.out_valid), 64'd1);
    chk("pre-rst data",  64'(if2.out_data),  64'(p2(8'h10, 8'h20)));
    #2 rst = 1'b1;
    #1;
    chk("async rst valid", 64'(if2.out_valid), 64'd0);
    chk("async rst data",  64'(if2.out_data),  64'd0);
    chk("async rst cntco", 64'(if2.cntco),     64'd0);
    rst = 1'b0;
    $display("async reset pending operand: valid=%0b data=0x%0h", if2.out_valid, if2.out_data);
    cyc2(1, 8'h01, 0, 1);
    cyc2(1, 8'h02, 0, 1);
    if2.ld = 0;
    chk("post-rst valid", 64'(if2.out_valid), 64'd1);
    chk("post-rst data",  64'(if2.out_data),  64'(p2(8'h01, 8'h02)));
    $display("post-reset operand: data=0x%0h", if2.out_data);

    // Four-word instance, one operand at full rate.
    wq.delete();
    if4.out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      if4.ld = 1; if4.bus = 8'((k + 1) * 8'h11);
      wq.push_back(if4.bus);
      @(posedge clk);
      #1;
      chk($sformatf("w4 cnt%0d", k),   64'(if4.cnt),       64'((k + 1) % 4));
      chk($sformatf("w4 valid%0d", k), 64'(if4.out_valid), 64'(k == 3));
      chk($sformatf("w4 cntco%0d", k), 64'(if4.cntco),     64'(k == 3));
      $display("w4 word%0d: bus=0x%0h -> cnt=%0d valid=%0b", k, wq[k], if4.cnt, if4.out_valid);
    end
    chk("w4 data", 64'(if4.out_data), 64'(pack(wq)));
    $display("w4 operand: data=0x%0h", if4.out_data);
    if4.ld = 0;

    // Randomized run on the four-word instance against a queue model.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    part.delete(); sb.delete();
    md = '0; mv = 0; n_done = 0; n_co = 0;
    for (int c = 0; c < 10000; c++) begin
      r_ld   = ($urandom_range(0, 3) != 0);
      r_clr  = ($urandom_range(0, 15) == 0);
      r_ordy = ($urandom_range(0, 2) != 0);
      r_bus  = 8'($urandom);
      if4.ld = r_ld; if4.clr = r_clr; if4.out_ready = r_ordy; if4.bus = r_bus;
      #1;
      e_rdy = (part.size() != 3) || !mv || r_ordy;
      chk("rnd ld_ready", 64'(if4.ld_ready), 64'(e_rdy));
      if (mv && r_ordy) begin
        if (sb.size() == 0) begin
          chk("rnd consume w/o operand", 64'd1, 64'd0);
        end else begin
          chk("rnd consumed data", 64'(if4.out_data), 64'(sb.pop_front()));
        end
        mv = 0;
      end
      done = 0;
      if (r_clr) begin
        part.delete();
      end else if (r_ld && e_rdy) begin
        part.push_back(r_bus);
        if (part.size() == 4) begin
          nd = pack(part);
          part.delete();
          done = 1;
          md = nd;
          mv = 1;
          sb.push_back(nd);
          n_done++;
        end
      end
      @(posedge clk);
      #1;
      if (if4.cntco === 1'b1) n_co++;
      chk("rnd cnt",       64'(if4.cnt),       64'(part.size()));
      chk("rnd out_valid", 64'(if4.out_valid), 64'(mv));
      chk("rnd out_data",  64'(if4.out_data),  64'(md));
      chk("rnd cntco",     64'(if4.cntco),     64'(done));
    end
    if4.ld = 0; if4.clr = 0;
    chk("rnd cntco total", 64'(n_co), 64'(n_done));
    $display("random: %0d operands completed, %0d cntco pulses", n_done, n_co);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_word_packer.md
# bus_word_packer

Parametrised bus-to-wide-word assembler for the accelerator datapath. It collects `WORDS` consecutive `BUS_W`-bit words from the shared input bus into one `BUS_W*WORDS`-bit operand. It presents that operand to the downstream compute stage through a registered valid/ready output stage, with back-pressure to the bus-side controller. It is the generalised successor of the fixed two-byte operand wrapper: width, depth, packing order and flow control are all configurable.

## Interface
Parameters:
- `BUS_W`, 8: input bus word width in bits (≥1).
- `WORDS`, 2: words per assembled operand (≥2).
- `CNT_W`, `$clog2(WORDS)`: width of the word counter (derived; do not override).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `bus`, input, `BUS_W`: incoming data word.
- `ld`, input, 1: load strobe; word accepted when `ld && ld_ready`.
- `ld_ready`, output, 1: block can accept a word this cycle.
- `clr`, input, 1: synchronous abort of the partial assembly.
- `cnt`, output, `CNT_W`: number of words held in the current partial assembly.
- `out_data`, output, `BUS_W*WORDS`: assembled operand (registered).
- `out_valid`, output, 1: `out_data` holds an unconsumed operand.
- `out_ready`, input, 1: downstream accepts `out_data` when `out_valid && out_ready`.
- `cntco`, output, 1: one-cycle pulse, registered, high in the first cycle the new operand is on `out_data`.

## Operation
- Two storage stages: an assembly register (`WORDS-1` slots plus `cnt`) and an output register (`out_data`, `out_valid`).
- Accept (`ld && ld_ready && !clr`):
  - If `cnt < WORDS-1`: the word goes into slot `cnt`, then `cnt++`.
  - If `cnt == WORDS-1`: the word completes the operand. The full word is written to `out_data`, `out_valid` is set to 1, `cnt` is set to 0 and `cntco` is set to 1 on that same edge.
- Default packing: the first-accepted word occupies bits `[BUS_W-1:0]`; word k occupies `[k*BUS_W +: BUS_W]`.
- Consume: `out_valid && out_ready` clears `out_valid` on the edge, unless a completing word is accepted on the same edge. In that case `out_valid` stays 1 and `out_data` takes the new operand.
- Flow control: `ld_ready = (cnt != WORDS-1) | !out_valid | out_ready`. Partial words are always accepted; only the completing word stalls.
- `clr`:
  - Sets `cnt` to 0 and discards any partial slots.
  - `clr` has priority over a simultaneous `ld`, and that word is dropped.
  - `out_data`, `out_valid` and consumption are unaffected.
- `ld` while `ld_ready` is 0: ignored, with no state change. The source must hold the word.
- `cnt` is an output alias of the internal counter. It never exceeds `WORDS-1`.

## Timing
- Reset values:
  - `cnt` = 0.
  - All assembly slots = 0.
  - `out_data` = 0.
  - `out_valid` = 0.
  - `cntco` = 0.
  - `ld_ready` = 1 (combinational from reset state).
- Latency: the operand is visible on `out_data`/`out_valid` in the cycle after the completing word's accept edge. Minimum spacing is `WORDS` cycles per operand, giving full throughput at `ld` = 1 and `out_ready` = 1.
- `ld_ready` is combinational from `cnt`, `out_valid` and `out_ready`, with no path from `bus` or `ld`.
- `cntco` is high for exactly one cycle per completed operand, including back-to-back completions.
- Reset asserted mid-assembly or while `out_valid` is 1: all state is cleared immediately (asynchronously), and the partial assembly and the pending operand are lost.
- `out_data` is stable while `out_valid` is 1 and `out_ready` is 0.

## Configuration
- `PACKER_MSB_FIRST_EN`:
  - Defined: the first-accepted word goes to the most-significant slot `[(WORDS-1)*BUS_W +: BUS_W]`, and word k goes to `[(WORDS-1-k)*BUS_W +: BUS_W]`.
  - Undefined: default LSB-first packing as above.
  - Handshake, counter and timing are identical in both builds.

## Test plan
- Reset, then `BUS_W`=8, `WORDS`=2, send 0x34 then 0x12 with `out_ready`=1 → `out_data`=0x1234, `out_valid` and `cntco` high for 1 cycle, `cnt` sequence 0,1,0. With `PACKER_MSB_FIRST_EN` → `out_data`=0x3412.
- `WORDS`=4, `BUS_W`=8, words 0x11,0x22,0x33,0x44 → `out_data`=0x44332211; `cnt` 1,2,3,0; no `out_valid` before the 4th accept.
- `WORDS`=2, `out_ready`=0, `ld`=1 with 0xA1,0xA2,0xB1,0xB2 → operand 0xA2A1 held; 0xB1 accepted (`cnt`=1); `ld_ready`=0 for 0xB2. Raise `out_ready` → 0xB2 accepted on the consume edge and `out_data`=0xB2B1 with `out_valid` held at 1.
- Send 0x55 (`cnt`=1), then `clr`=1 with `ld`=1 and `bus`=0x66 → `cnt`=0, 0x66 dropped. Next 0x01,0x02 → `out_data`=0x0201.
- Assert `rst` mid-assembly (`cnt`=1) and again while `out_valid`=1 → all outputs are 0 immediately, without a clock edge; next operand assembles correctly.
- Random `ld`/`out_ready`/`clr` for 10k cycles against a scoreboard → no lost or duplicated operands, `cnt` ≤ `WORDS-1`, `cntco` count equals the number of completed operands.
